// File: rtl/uart_rx_if.sv
// Serial receive bundle: the rx line in, the recovered byte and its status strobes out.
// The receiver takes the master modport; the register/FIFO consumer takes the slave one.
interface uart_rx_if;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    modport master (
        input  rx_i,
        output data_o,
        output valid_o,
        output frame_err_o,
        output busy_o
    );

    modport slave (
        output rx_i,
        input  data_o,
        input  valid_o,
        input  frame_err_o,
        input  busy_o
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: 2-flop synchronizer, falling-edge start detection,
// and mid-bit sampling timed by a per-bit clock counter.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);
    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);

    generate
        if (CPB < 8) begin : g_cpb_check
            $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;

    logic rx_s;
    logic start_edge;

    assign rx_s       = rx_s2_q;
    // Edge registers reset low, so the line must be seen high before a fall can start a frame.
    assign start_edge = !rx_s && rx_prev_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rx_s1_q     <= 1'b0;
            rx_s2_q     <= 1'b0;
            rx_prev_q   <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shreg_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_s1_q     <= bus.rx_i;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.busy_o      = (state_q != IDLE);
endmodule
